// File: rtl/sha256_pkg.sv
// Shared SHA-256 definitions: FSM states, working-variable bundle,
// initial hash value, round constants and the round helper functions.
package sha256_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_LEAD,
    ST_PREFETCH,
    ST_ROUND,
    ST_FINAL,
    ST_DONE
  } state_t;

  // Working variables a..h; a occupies the top 32 bits so that a 256-bit
  // chaining value {H0..H7} casts directly onto it.
  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] c;
    logic [31:0] d;
    logic [31:0] e;
    logic [31:0] f;
    logic [31:0] g;
    logic [31:0] h;
  } work_t;

  localparam logic [255:0] IV = {
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  localparam logic [0:63][31:0] K_TABLE = {
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
    32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
    32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
    32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
    32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  function automatic logic [31:0] rotr(input logic [31:0] x, input int unsigned n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] k_const(input logic [5:0] t);
    return K_TABLE[t];
  endfunction

  function automatic logic [31:0] big_sigma0(input logic [31:0] x);
    return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
  endfunction

  function automatic logic [31:0] big_sigma1(input logic [31:0] x);
    return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
  endfunction

  function automatic logic [31:0] ch(input logic [31:0] x, input logic [31:0] y,
                                     input logic [31:0] z);
    return (x & y) ^ (~x & z);
  endfunction

  function automatic logic [31:0] maj(input logic [31:0] x, input logic [31:0] y,
                                      input logic [31:0] z);
    return (x & y) ^ (x & z) ^ (y & z);
  endfunction

  // Word-wise modulo-2^32 addition of two bundles (chaining-value update).
  function automatic work_t add_work(input work_t x, input work_t y);
    work_t r;
    r.a = x.a + y.a;
    r.b = x.b + y.b;
    r.c = x.c + y.c;
    r.d = x.d + y.d;
    r.e = x.e + y.e;
    r.f = x.f + y.f;
    r.g = x.g + y.g;
    r.h = x.h + y.h;
    return r;
  endfunction

endpackage

// File: rtl/run_comp_round.sv
// One SHA-256 compression round, purely combinational.
module run_comp_round
  import sha256_pkg::*;
(
  input  work_t       work_in,
  input  logic [31:0] k,
  input  logic [31:0] w,
  output work_t       work_out
);

  logic [31:0] t1;
  logic [31:0] t2;

  assign t1 = work_in.h + big_sigma1(work_in.e) + ch(work_in.e, work_in.f, work_in.g) + k + w;
  assign t2 = big_sigma0(work_in.a) + maj(work_in.a, work_in.b, work_in.c);

  // Shift the working variables down by one and inject the new a and e.
  always_comb begin
    work_out   = work_in;
    work_out.a = t1 + t2;
    work_out.b = work_in.a;
    work_out.c = work_in.b;
    work_out.d = work_in.c;
    work_out.e = work_in.d + t1;
    work_out.f = work_in.e;
    work_out.g = work_in.f;
    work_out.h = work_in.g;
  end

endmodule

// File: rtl/run_comp.sv
// SHA-256 compression engine: starts the W generator, streams W[0..63]
// through its two-cycle read port, runs 64 rounds and folds the result
// into the chaining value presented as the digest.
module run_comp
  import sha256_pkg::*;
#(
  parameter int W_LEAD = 4
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         go,
  input  logic         init,
  output logic         w_go,
  input  logic         w_rdy,
  output logic         w_read,
  output logic [5:0]   w_addr,
  input  logic [31:0]  w_data,
  output logic         busy,
  output logic         done,
  output logic [255:0] digest
);

  state_t      state, state_next;
  logic [5:0]  cnt, cnt_next;
  logic        w_go_next, w_read_next, busy_next, done_next;
  logic [5:0]  w_addr_next;
  logic        load_iv, load_work, do_round, do_final;
  logic [255:0] h_state;
  work_t       work, round_out;

  run_comp_round u_round (
    .work_in  (work),
    .k        (k_const(cnt)),
    .w        (w_data),
    .work_out (round_out)
  );

  assign digest = h_state;

  // Next-state and next-output decode. The read address runs two ahead of
  // the round index because the W read port has two cycles of latency.
  always_comb begin
    state_next  = state;
    cnt_next    = cnt;
    w_go_next   = w_go;
    w_read_next = 1'b0;
    w_addr_next = w_addr;
    busy_next   = busy;
    done_next   = done;
    load_iv     = 1'b0;
    load_work   = 1'b0;
    do_round    = 1'b0;
    do_final    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (go) begin
          state_next = ST_START;
          w_go_next  = 1'b1;
          busy_next  = 1'b1;
          load_iv    = init;
        end
      end
      ST_START: begin
        if (w_rdy) begin
          state_next = ST_LEAD;
          cnt_next   = '0;
        end
      end
      ST_LEAD: begin
        if (cnt == 6'(W_LEAD - 1)) begin
          state_next  = ST_PREFETCH;
          cnt_next    = '0;
          load_work   = 1'b1;
          w_read_next = 1'b1;
          w_addr_next = 6'd0;
        end else begin
          cnt_next = cnt + 6'd1;
        end
      end
      ST_PREFETCH: begin
        w_read_next = 1'b1;
        if (cnt == 6'd0) begin
          cnt_next    = 6'd1;
          w_addr_next = 6'd1;
        end else begin
          state_next  = ST_ROUND;
          cnt_next    = '0;
          w_addr_next = 6'd2;
        end
      end
      ST_ROUND: begin
        do_round = 1'b1;
        if (cnt <= 6'd60) begin
          w_read_next = 1'b1;
          w_addr_next = cnt + 6'd3;
        end
        if (cnt == 6'd63) begin
          state_next = ST_FINAL;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt + 6'd1;
        end
      end
      ST_FINAL: begin
        do_final   = 1'b1;
        state_next = ST_DONE;
        w_go_next  = 1'b0;
        busy_next  = 1'b0;
        done_next  = 1'b1;
      end
      ST_DONE: begin
        if (!go) begin
          state_next  = ST_IDLE;
          done_next   = 1'b0;
          w_addr_next = 6'd0;
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // State register and registered control outputs.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state  <= ST_IDLE;
      cnt    <= '0;
      w_go   <= 1'b0;
      w_read <= 1'b0;
      w_addr <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      state  <= state_next;
      cnt    <= cnt_next;
      w_go   <= w_go_next;
      w_read <= w_read_next;
      w_addr <= w_addr_next;
      busy   <= busy_next;
      done   <= done_next;
    end
  end

  // Chaining value and working variables; H only moves on IV load or FINAL.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      h_state <= IV;
      work    <= '0;
    end else begin
      if (load_iv) begin
        h_state <= IV;
      end else if (do_final) begin
        h_state <= add_work(work_t'(h_state), work);
      end
      if (load_work) begin
        work <= work_t'(h_state);
      end else if (do_round) begin
        work <= round_out;
      end
    end
  end

endmodule

// File: tb/tb_run_comp.sv
// Bench for run_comp with a behavioural W-schedule generator and
// two-cycle read port standing in for gen_w.
module tb_run_comp;

  localparam int W_LEAD  = 4;
  localparam int RDY_LAT = 3;
  localparam logic [255:0] IV_EXP  = 256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;
  localparam logic [255:0] ABC_EXP = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
  localparam logic [255:0] EMP_EXP = 256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;
  localparam logic [255:0] TWO_EXP = 256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;
  localparam logic [511:0] ABC_BLK = {32'h61626380, 448'h0, 32'h00000018};
  localparam logic [511:0] EMP_BLK = {32'h80000000, 480'h0};
  localparam logic [511:0] B1_BLK  = {32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
                                      32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
                                      32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
                                      32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
  localparam logic [511:0] B2_BLK  = {480'h0, 32'h000001c0};

  logic         clock = 1'b0;
  logic         reset_n;
  logic         go, init;
  logic         w_go, w_rdy, w_read;
  logic [5:0]   w_addr;
  logic [31:0]  w_data;
  logic         busy, done;
  logic [255:0] digest;

  int checks = 0;
  int errors = 0;

  logic [31:0] sched [64];
  logic [31:0] mem   [64];
  int          rdy_cnt;
  logic [5:0]  rd_addr_q;
  logic        rd_q;

  int   n_reads, addr_errs, busy_drops, rdy_cyc, read_cyc, done_cyc;
  logic timed_out, w_go_at_done, busy_at_done;

  typedef struct {
    string        name;
    logic [511:0] blk;
    logic         init_v;
    logic         drop_go;
    logic         chk_dig;
    logic [255:0] exp;
  } vec_t;
  vec_t vecs [4];

  run_comp #(.W_LEAD(W_LEAD)) dut (
    .clock  (clock),
    .reset_n(reset_n),
    .go     (go),
    .init   (init),
    .w_go   (w_go),
    .w_rdy  (w_rdy),
    .w_read (w_read),
    .w_addr (w_addr),
    .w_data (w_data),
    .busy   (busy),
    .done   (done),
    .digest (digest)
  );

  always #5 clock = ~clock;

  // gen_w stand-in: rdy rises RDY_LAT cycles after w_go, with the schedule loaded.
  always @(posedge clock) begin
    if (!reset_n || !w_go) begin
      w_rdy   <= 1'b0;
      rdy_cnt <= 0;
    end else if (!w_rdy) begin
      if (rdy_cnt == RDY_LAT - 1) begin
        w_rdy <= 1'b1;
        mem   <= sched;
      end else begin
        rdy_cnt <= rdy_cnt + 1;
      end
    end
  end

  // Register-file read port: data appears two cycles after the request.
  always @(posedge clock) begin
    rd_addr_q <= w_addr;
    rd_q      <= w_read;
    if (rd_q) w_data <= mem[rd_addr_q];
  end

  function automatic logic [31:0] rr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  task automatic load_sched(input logic [511:0] blk);
    logic [31:0] s0, s1;
    for (int i = 0; i < 16; i++) sched[i] = blk[511 - 32*i -: 32];
    for (int i = 16; i < 64; i++) begin
      s0 = rr(sched[i-15], 7) ^ rr(sched[i-15], 18) ^ (sched[i-15] >> 3);
      s1 = rr(sched[i-2], 17) ^ rr(sched[i-2], 19) ^ (sched[i-2] >> 10);
      sched[i] = s1 + sched[i-7] + s0 + sched[i-16];
    end
  endtask

  task automatic checkOutput(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Waits for done while monitoring the read port, rdy and busy.
  task automatic wait_done(input logic drop_go, input logic init_v);
    int cyc;
    cyc = 0;
    n_reads = 0; addr_errs = 0; busy_drops = 0;
    rdy_cyc = -1; read_cyc = -1; done_cyc = -1; timed_out = 1'b0;
    while (1) begin
      @(negedge clock);
      cyc++;
      if (w_rdy && rdy_cyc < 0) rdy_cyc = cyc;
      if (w_read) begin
        if (read_cyc < 0) read_cyc = cyc;
        if (w_addr != 6'(n_reads)) addr_errs++;
        n_reads++;
      end
      if (done) break;
      if (cyc >= 2 && !busy) busy_drops++;
      if (cyc >= 400) begin
        timed_out = 1'b1;
        break;
      end
      if (cyc == 3) init = ~init_v;
      if (drop_go && cyc == 40) go = 1'b0;
    end
    done_cyc     = cyc;
    w_go_at_done = w_go;
    busy_at_done = busy;
  endtask

  task automatic applyStimulus(input logic [511:0] blk, input logic init_v, input logic drop_go);
    load_sched(blk);
    @(posedge clock);
    #1;
    go   = 1'b1;
    init = init_v;
    wait_done(drop_go, init_v);
  endtask

  task automatic check_run(input string name);
    checkOutput({name, " timeout"}, 256'(timed_out), 256'(0));
    checkOutput({name, " reads"}, 256'(n_reads), 256'(64));
    checkOutput({name, " addr order"}, 256'(addr_errs), 256'(0));
    checkOutput({name, " busy"}, 256'(busy_drops), 256'(0));
    checkOutput({name, " first read"}, 256'(read_cyc - rdy_cyc), 256'(W_LEAD + 1));
    checkOutput({name, " latency"}, 256'(done_cyc - rdy_cyc), 256'(W_LEAD + 2 + 64 + 1 + 1));
    checkOutput({name, " w_go at done"}, 256'(w_go_at_done), 256'(0));
    checkOutput({name, " busy at done"}, 256'(busy_at_done), 256'(0));
  endtask

  initial begin
    int   bad;
    logic found;

    vecs[0] = '{name: "abc",    blk: ABC_BLK, init_v: 1'b1, drop_go: 1'b0, chk_dig: 1'b1, exp: ABC_EXP};
    vecs[1] = '{name: "empty",  blk: EMP_BLK, init_v: 1'b1, drop_go: 1'b1, chk_dig: 1'b1, exp: EMP_EXP};
    vecs[2] = '{name: "two_b1", blk: B1_BLK,  init_v: 1'b1, drop_go: 1'b0, chk_dig: 1'b0, exp: '0};
    vecs[3] = '{name: "two_b2", blk: B2_BLK,  init_v: 1'b0, drop_go: 1'b0, chk_dig: 1'b1, exp: TWO_EXP};

    reset_n = 1'b0;
    go      = 1'b0;
    init    = 1'b0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    checkOutput("reset ctrl", {w_go, w_read, busy, done, w_addr}, 10'd0);
    checkOutput("reset digest", digest, IV_EXP);
    reset_n = 1'b1;
    repeat (2) @(negedge clock);
    checkOutput("idle ctrl", {w_go, w_read, busy, done}, 4'd0);

    for (int i = 0; i < 4; i++) begin
      applyStimulus(vecs[i].blk, vecs[i].init_v, vecs[i].drop_go);
      check_run(vecs[i].name);
      if (vecs[i].chk_dig) checkOutput({vecs[i].name, " digest"}, digest, vecs[i].exp);
      @(posedge clock);
      #1 go = 1'b0;
      repeat (2) @(negedge clock);
      checkOutput({vecs[i].name, " done cleared"}, 256'(done), 256'(0));
    end

    // Reset in the middle of round 30, then chain from H: must be IV again.
    load_sched(ABC_BLK);
    @(posedge clock);
    #1 go = 1'b1; init = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      @(negedge clock);
      if (w_read) found = 1'b1;
    end
    checkOutput("rst first read seen", 256'(found), 256'(1));
    repeat (32) @(negedge clock);
    checkOutput("rst busy before", 256'(busy), 256'(1));
    reset_n = 1'b0;
    #1;
    checkOutput("rst async ctrl", {w_go, w_read, busy, done, w_addr}, 10'd0);
    checkOutput("rst async digest", digest, IV_EXP);
    go = 1'b0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    repeat (3) @(posedge clock);
    applyStimulus(ABC_BLK, 1'b0, 1'b0);
    check_run("abc after rst");
    checkOutput("abc after rst digest", digest, ABC_EXP);

    // go held high after done: no restart; one low cycle starts a new block.
    @(posedge clock);
    #1 go = 1'b0;
    repeat (2) @(negedge clock);
    applyStimulus(ABC_BLK, 1'b1, 1'b0);
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      if (!done || busy || w_go || w_read || digest !== ABC_EXP) bad++;
    end
    checkOutput("hold no restart", 256'(bad), 256'(0));
    @(posedge clock);
    #1 go = 1'b0;
    applyStimulus(EMP_BLK, 1'b1, 1'b0);
    check_run("restart");
    checkOutput("restart digest", digest, EMP_EXP);
    @(posedge clock);
    #1 go = 1'b0;
    repeat (2) @(negedge clock);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
